bank_memory: RTL and testbench

BANK_MEMORY -- requirements
Module: bank_memory

---
 rtl/bank_memory_pkg.sv | 38 +++
 rtl/bank_memory_bank.sv | 51 +++++
 rtl/bank_memory.sv | 87 ++++++++
 tb/tb_bank_memory.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bank_memory_pkg.sv
// Shared memory-system constants, address field positions and read-pipeline types
// for the four-bank interleaved memory.
package bank_memory_pkg;

  localparam int BANK_CNT    = 4;
  localparam int BANK_WORDS  = 8192;
  localparam int BUSY_CYCLES = 4;
  localparam int RD_LAT      = 2;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;

  // addr[0] is the byte-select bit, then the bank field, then the word index
  localparam int BANK_LSB = 1;
  localparam int BANK_W   = $clog2(BANK_CNT);
  localparam int WORD_LSB = BANK_LSB + BANK_W;
  localparam int WORD_W   = $clog2(BANK_WORDS);

  localparam int                CNT_W     = $clog2(BUSY_CYCLES);
  localparam logic [CNT_W-1:0]  BUSY_LOAD = CNT_W'(BUSY_CYCLES - 1);

  typedef logic [BANK_W-1:0] bank_idx_t;
  typedef logic [WORD_W-1:0] word_idx_t;

  typedef struct packed {
    logic      valid;
    bank_idx_t bank;
  } rd_stage_t;

  function automatic bank_idx_t bank_of(input logic [ADDR_W-1:0] a);
    return a[BANK_LSB +: BANK_W];
  endfunction

  function automatic word_idx_t word_of(input logic [ADDR_W-1:0] a);
    return a[WORD_LSB +: WORD_W];
  endfunction

endpackage

// File: rtl/bank_memory_bank.sv
// One memory bank: word array with registered read port plus the busy counter
// that blocks the bank for the cycles following an access.
module mem_bank
  import bank_memory_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic              re_i,
  input  word_idx_t         word_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              busy_o
);

  logic [DATA_W-1:0] mem_array [BANK_WORDS];
  logic [DATA_W-1:0] rdata_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;

  // Array has no reset so it maps onto block RAM and survives rst_n
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_array[word_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_array[word_i];
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (we_i || re_i) begin
      cnt_d = BUSY_LOAD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy_o  = (cnt_q != '0);
  assign rdata_o = rdata_q;

endmodule

// File: rtl/bank_memory.sv
// Four-bank interleaved memory: request decode, err/stall generation and the
// read pipeline that returns bank data a fixed latency after acceptance.
module bank_memory
  import bank_memory_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   data_in,
  input  logic                wr,
  input  logic                rd,
  output logic [DATA_W-1:0]   data_out,
  output logic                stall,
  output logic [BANK_CNT-1:0] busy,
  output logic                err
);

  bank_idx_t           req_bank;
  word_idx_t           req_word;
  logic                req_legal;
  logic                req_accept;
  logic [BANK_CNT-1:0] bank_we;
  logic [BANK_CNT-1:0] bank_re;
  logic [DATA_W-1:0]   bank_rdata [BANK_CNT];
  rd_stage_t           pipe_q [RD_LAT-1];
  logic [DATA_W-1:0]   data_out_q;
  logic [DATA_W-1:0]   data_out_d;

  assign req_bank = bank_of(addr);
  assign req_word = word_of(addr);

  // Gating with rst_n keeps err/stall low and blocks array writes during reset
  assign req_legal  = rst_n & (rd ^ wr) & ~addr[0];
  assign req_accept = req_legal & ~busy[req_bank];
  assign stall      = req_legal & busy[req_bank];
  assign err        = rst_n & ((rd & wr) | ((rd | wr) & addr[0]));

  generate
    for (genvar gi = 0; gi < BANK_CNT; gi++) begin : g_bank
      assign bank_we[gi] = req_accept & wr & (req_bank == bank_idx_t'(gi));
      assign bank_re[gi] = req_accept & rd & (req_bank == bank_idx_t'(gi));

      mem_bank u_bank (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (bank_we[gi]),
        .re_i    (bank_re[gi]),
        .word_i  (req_word),
        .wdata_i (data_in),
        .rdata_o (bank_rdata[gi]),
        .busy_o  (busy[gi])
      );
    end
  endgenerate

  // Bank data is registered one cycle after accept and held while the bank is busy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT - 1; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= '{valid: req_accept & rd, bank: req_bank};
      for (int i = 1; i < RD_LAT - 1; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  always_comb begin
    data_out_d = '0;
    if (pipe_q[RD_LAT-2].valid) begin
      data_out_d = bank_rdata[pipe_q[RD_LAT-2].bank];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out_q <= '0;
    end else begin
      data_out_q <= data_out_d;
    end
  end

  assign data_out = data_out_q;

endmodule

// File: tb/tb_bank_memory.sv
// Self-checking bench for bank_memory: directed scenarios plus random traffic
// compared cycle by cycle against a timeline model of banks and read returns.
module tb_bank_memory;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] addr = '0;
  logic [15:0] data_in = '0;
  logic        wr = 1'b0;
  logic        rd = 1'b0;
  logic [15:0] data_out;
  logic        stall;
  logic [3:0]  busy;
  logic        err;

  bank_memory dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .addr     (addr),
    .data_in  (data_in),
    .wr       (wr),
    .rd       (rd),
    .data_out (data_out),
    .stall    (stall),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int cyc = 0;

  // Model: memory keyed by addr[15:1], cycle at which each bank is free again,
  // and the word expected on data_out in a given cycle.
  logic [15:0] mm [int];
  int          bank_free [4];
  logic [15:0] out_sched [int];
  logic [21:0] exp_vec;
  logic [21:0] obs_vec;

  assign obs_vec = {err, stall, busy, data_out};

  // Starts a new cycle, applies inputs, computes expectations, parks at negedge
  task automatic drive(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
    logic        legal;
    logic        e_err;
    logic        e_stall;
    logic [3:0]  e_busy;
    logic [15:0] e_dout;
    int          b;
    @(posedge clk);
    #1;
    cyc++;
    rd = r; wr = w; addr = a; data_in = d;
    b = int'(a[2:1]);
    legal = (r ^ w) && !a[0];
    e_err = (r && w) || ((r || w) && a[0]);
    for (int i = 0; i < 4; i++) e_busy[i] = (cyc < bank_free[i]);
    e_stall = legal && e_busy[b];
    e_dout = out_sched.exists(cyc) ? out_sched[cyc] : 16'h0000;
    if (out_sched.exists(cyc)) out_sched.delete(cyc);
    if (legal && !e_busy[b]) begin
      bank_free[b] = cyc + 4;
      if (w) mm[int'(a[15:1])] = d;
      else   out_sched[cyc + 2] = mm[int'(a[15:1])];
    end
    exp_vec = {e_err, e_stall, e_busy, e_dout};
    @(negedge clk);
  endtask

  task automatic apply_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      rd = 1'b0; wr = 1'b0; rst_n = 1'b0;
      @(negedge clk);
      checks++;
      if (obs_vec !== 22'h0) $display("FAIL in_reset cyc=%0d got=%h want=%h", cyc, obs_vec, 22'h0);
      else passes++;
    end
    rst_n = 1'b1;
    for (int b = 0; b < 4; b++) bank_free[b] = 0;
    out_sched.delete();
  endtask

  task automatic test_reset();
    apply_reset(2);
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, 16'h0000, 16'h0000);
      checks++;
      if (obs_vec !== exp_vec) $display("FAIL reset_idle cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec);
      else passes++;
    end
  endtask

  task automatic test_write_read();
    for (int i = 0; i < 8; i++) begin
      if (i == 0)      drive(1'b0, 1'b1, 16'h0010, 16'hBEEF);
      else if (i == 4) drive(1'b1, 1'b0, 16'h0010, 16'h0000);
      else             drive(1'b0, 1'b0, 16'h0000, 16'h0000);
      checks++;
      if (obs_vec !== exp_vec) $display("FAIL write_read cyc=%0d i=%0d got=%h want=%h", cyc, i, obs_vec, exp_vec);
      else passes++;
      if (i == 6) begin
        checks++;
        if (data_out !== 16'hBEEF) $display("FAIL write_read_data got=%h want=%h", data_out, 16'hBEEF);
        else passes++;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] vals [4];
    for (int b = 0; b < 8; b++) begin
      if (b < 4) begin
        vals[b] = 16'($urandom);
        drive(1'b0, 1'b1, 16'h0100 + 16'(2 * b), vals[b]);
      end else begin
        drive(1'b0, 1'b0, 16'h0000, 16'h0000);
      end
      checks++;
      if (obs_vec !== exp_vec) $display("FAIL b2b_fill cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec);
      else passes++;
    end
    for (int i = 0; i < 8; i++) begin
      if (i < 4) drive(1'b1, 1'b0, 16'h0100 + 16'(2 * i), 16'h0000);
      else       drive(1'b0, 1'b0, 16'h0000, 16'h0000);
      checks++;
      if (obs_vec !== exp_vec) $display("FAIL b2b cyc=%0d i=%0d got=%h want=%h", cyc, i, obs_vec, exp_vec);
      else passes++;
      checks++;
      if (stall !== 1'b0) $display("FAIL b2b_stall i=%0d got=%b want=0", i, stall);
      else passes++;
      if (i >= 2 && i <= 5) begin
        checks++;
        if (data_out !== vals[i-2]) $display("FAIL b2b_data i=%0d got=%h want=%h", i, data_out, vals[i-2]);
        else passes++;
      end
    end
  endtask

  task automatic test_stall();
    logic [15:0] v;
    v = 16'($urandom);
    for (int i = 0; i < 5; i++) begin
      if (i == 0) drive(1'b0, 1'b1, 16'h0008, v);
      else        drive(1'b0, 1'b0, 16'h0000, 16'h0000);
      checks++;
      if (obs_vec !== exp_vec) $display("FAIL stall_fill cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec);
      else passes++;
    end
    for (int i = 0; i < 8; i++) begin
      if (i == 0)      drive(1'b1, 1'b0, 16'h0008, 16'h0000);
      else if (i <= 4) drive(1'b1, 1'b0, 16'h0010, 16'h0000);
      else             drive(1'b0, 1'b0, 16'h0000, 16'h0000);
      checks++;
      if (obs_vec !== exp_vec) $display("FAIL stall cyc=%0d i=%0d got=%h want=%h", cyc, i, obs_vec, exp_vec);
      else passes++;
      checks++;
      if (stall !== (i >= 1 && i <= 3)) $display("FAIL stall_flag i=%0d got=%b", i, stall);
      else passes++;
      if (i == 2 || i == 6) begin
        checks++;
        if (data_out !== ((i == 2) ? v : 16'hBEEF))
          $display("FAIL stall_data i=%0d got=%h want=%h", i, data_out, (i == 2) ? v : 16'hBEEF);
        else passes++;
      end
    end
  endtask

  task automatic test_err();
    for (int i = 0; i < 8; i++) begin
      case (i)
        0:       drive(1'b1, 1'b1, 16'h0100, 16'hDEAD);
        1:       drive(1'b1, 1'b0, 16'h0003, 16'h0000);
        2:       drive(1'b0, 1'b1, 16'h0101, 16'hDEAD);
        4:       drive(1'b1, 1'b0, 16'h0100, 16'h0000);
        default: drive(1'b0, 1'b0, 16'h0000, 16'h0000);
      endcase
      checks++;
      if (obs_vec !== exp_vec) $display("FAIL err cyc=%0d i=%0d got=%h want=%h", cyc, i, obs_vec, exp_vec);
      else passes++;
      if (i < 3) begin
        checks++;
        if ({err, stall, busy, data_out} !== {2'b10, 4'b0000, 16'h0000})
          $display("FAIL err_flags i=%0d got=%b%b_%b_%h want=10_0000_0000", i, err, stall, busy, data_out);
        else passes++;
      end
    end
  endtask

  task automatic test_reset_midflight();
    drive(1'b1, 1'b0, 16'h0102, 16'h0000);
    checks++;
    if (obs_vec !== exp_vec) $display("FAIL midflight_rd cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec);
    else passes++;
    apply_reset(2);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 16'h0000, 16'h0000);
      checks++;
      if (data_out !== 16'h0000 || obs_vec !== exp_vec)
        $display("FAIL midflight cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec);
      else passes++;
    end
  endtask

  task automatic test_reset_array();
    for (int i = 0; i < 5; i++) begin
      if (i == 0) drive(1'b0, 1'b1, 16'h0020, 16'h1234);
      else        drive(1'b0, 1'b0, 16'h0000, 16'h0000);
      checks++;
      if (obs_vec !== exp_vec) $display("FAIL keep_fill cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec);
      else passes++;
    end
    apply_reset(2);
    for (int i = 0; i < 4; i++) begin
      if (i == 0) drive(1'b1, 1'b0, 16'h0020, 16'h0000);
      else        drive(1'b0, 1'b0, 16'h0000, 16'h0000);
      checks++;
      if (obs_vec !== exp_vec) $display("FAIL keep cyc=%0d i=%0d got=%h want=%h", cyc, i, obs_vec, exp_vec);
      else passes++;
      if (i == 2) begin
        checks++;
        if (data_out !== 16'h1234) $display("FAIL keep_data got=%h want=%h", data_out, 16'h1234);
        else passes++;
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] pool [8];
    logic [15:0] a;
    int          sel;
    for (int k = 0; k < 8; k++) begin
      pool[k] = {13'($urandom), 2'(k % 4), 1'b0};
      for (int j = 0; j < 4; j++) begin
        if (j == 0) drive(1'b0, 1'b1, pool[k], 16'($urandom));
        else        drive(1'b0, 1'b0, 16'h0000, 16'h0000);
        checks++;
        if (obs_vec !== exp_vec) $display("FAIL rand_fill cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec);
        else passes++;
      end
    end
    for (int n = 0; n < 300; n++) begin
      sel = int'($urandom_range(0, 9));
      a = pool[$urandom_range(0, 7)];
      case (sel)
        0, 1:    drive(1'b0, 1'b0, a, 16'($urandom));
        2, 3, 4: drive(1'b1, 1'b0, a, 16'h0000);
        5, 6, 7: drive(1'b0, 1'b1, a, 16'($urandom));
        8:       drive(1'b1, 1'b1, a, 16'($urandom));
        default: drive(1'b1, 1'($urandom), a | 16'h0001, 16'($urandom));
      endcase
      checks++;
      if (obs_vec !== exp_vec) $display("FAIL random cyc=%0d addr=%h got=%h want=%h", cyc, a, obs_vec, exp_vec);
      else passes++;
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 16'h0000, 16'h0000);
      checks++;
      if (obs_vec !== exp_vec) $display("FAIL rand_drain cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec);
      else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_stall();
    test_err();
    test_reset_midflight();
    test_reset_array();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
